// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared defaults, opcode and FSM state types for exec_unit
package exec_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;

    typedef enum logic [2:0] {
        OP_MV  = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SHL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - iterative shift-add multiplier, one partial product per cycle
module seq_mul
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] w_acc_nxt;

    // Product is presented combinationally so the caller can latch it on the final step edge
    assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_cnt == CNT_W'(DATA_W - 1));
    assign o_product = w_acc_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute/write-back stage; MUL support enabled by EXEC_MUL_EN
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [2:0]        i_op,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_ws,
    input  logic [DATA_W-1:0] i_imm,
    input  logic              i_use_imm,
    output logic [REG_AW-1:0] o_rs1,
    output logic [REG_AW-1:0] o_rs2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic [REG_AW-1:0] o_ws,
    output logic [DATA_W-1:0] o_wd,
    output logic              o_we,
    output logic              o_z,
    output logic              o_n,
    output logic              o_illegal
);

    localparam int SH_W = $clog2(DATA_W);

    state_e            r_state;
    state_e            w_state_nxt;
    op_e               r_op;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_ws;
    logic [DATA_W-1:0] r_imm;
    logic              r_use_imm;
    logic [DATA_W-1:0] r_wd;
    logic              r_z;
    logic              r_n;
    logic              r_illegal;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_res;
    logic              w_wb_load;
    logic              w_is_mul;

    assign w_is_mul = (r_op == OP_MUL);
    assign w_b      = r_use_imm ? r_imm : rd2;

    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_MV:   w_alu = w_b;
            OP_ADD:  w_alu = rd1 + w_b;
            OP_SUB:  w_alu = rd1 - w_b;
            OP_AND:  w_alu = rd1 & w_b;
            OP_OR:   w_alu = rd1 | w_b;
            OP_XOR:  w_alu = rd1 ^ w_b;
            OP_SHL:  w_alu = rd1 << w_b[SH_W-1:0];
            default: w_alu = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_product;

    // Operands are sampled on the EXEC edge, same as the single-cycle ALU path
    assign w_mul_start = (r_state == S_EXEC) && w_is_mul;

    seq_mul #(
        .DATA_W(DATA_W)
    ) u_seq_mul (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_start  (w_mul_start),
        .i_a      (rd1),
        .i_b      (w_b),
        .o_busy   (w_mul_busy),
        .o_done   (w_mul_done),
        .o_product(w_mul_product)
    );

    assign w_res     = (r_state == S_MUL) ? w_mul_product : w_alu;
    assign w_wb_load = ((r_state == S_EXEC) && !w_is_mul) ||
                       ((r_state == S_MUL) && w_mul_done);
`else
    assign w_res     = w_alu;
    assign w_wb_load = (r_state == S_EXEC) && !w_is_mul;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!w_is_mul) begin
                    w_state_nxt = S_WB;
                end else begin
`ifdef EXEC_MUL_EN
                    w_state_nxt = S_MUL;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
`ifdef EXEC_MUL_EN
            S_MUL: begin
                if (w_mul_done) begin
                    w_state_nxt = S_WB;
                end else if (!w_mul_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_MV;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_ws      <= '0;
            r_imm     <= '0;
            r_use_imm <= 1'b0;
            r_wd      <= '0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && i_valid) begin
                r_op      <= op_e'(i_op);
                r_rs1     <= i_rs1;
                r_rs2     <= i_rs2;
                r_ws      <= i_ws;
                r_imm     <= i_imm;
                r_use_imm <= i_use_imm;
            end
            // Flags move together with the write data so they describe the result being written
            if (w_wb_load) begin
                r_wd <= w_res;
                r_z  <= (w_res == '0);
                r_n  <= w_res[DATA_W-1];
            end
`ifdef EXEC_MUL_EN
            r_illegal <= 1'b0;
`else
            r_illegal <= (r_state == S_EXEC) && w_is_mul;
`endif
        end
    end

    assign i_ready   = (r_state == S_IDLE) && reset_n;
    assign o_rs1     = r_rs1;
    assign o_rs2     = r_rs2;
    assign o_ws      = r_ws;
    assign o_wd      = r_wd;
    assign o_we      = (r_state == S_WB);
    assign o_z       = r_z;
    assign o_n       = r_n;
    assign o_illegal = r_illegal;

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - randomized self-checking bench for exec_unit against a cycle-level behavioural model
module tb_exec_unit;

`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [2:0]  i_op = '0;
    logic [2:0]  i_rs1 = '0, i_rs2 = '0, i_ws = '0;
    logic [15:0] i_imm = '0;
    logic        i_use_imm = 1'b0;
    logic [2:0]  o_rs1, o_rs2, o_ws;
    logic [15:0] rd1, rd2, o_wd;
    logic        o_we, o_z, o_n, o_illegal;

    always #5 clk = ~clk;

    exec_unit dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_ready(i_ready),
        .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_ws(i_ws), .i_imm(i_imm),
        .i_use_imm(i_use_imm), .o_rs1(o_rs1), .o_rs2(o_rs2), .rd1(rd1), .rd2(rd2),
        .o_ws(o_ws), .o_wd(o_wd), .o_we(o_we), .o_z(o_z), .o_n(o_n), .o_illegal(o_illegal)
    );

    // Register file seen by the DUT: combinational read, write on o_we
    logic [15:0] tb_rf [8];
    assign rd1 = tb_rf[o_rs1];
    assign rd2 = tb_rf[o_rs2];
    always @(posedge clk) if (o_we === 1'b1) tb_rf[o_ws] <= o_wd;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;
    int we_count = 0;
    int ill_count = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_op(input int op, input int unsigned a, input int unsigned b);
        int unsigned x;
        case (op)
            0: x = b;
            1: x = a + b;
            2: x = a - b;
            3: x = a & b;
            4: x = a | b;
            5: x = a ^ b;
            6: x = a << (b % 16);
            default: x = a * b;
        endcase
        return x[15:0];
    endfunction

    // Model: each accepted instruction schedules one write (or an illegal pulse) at a fixed cycle
    int          m_idle_from = 0;
    int          m_we_at = -1;
    int          m_ill_at = -1;
    logic [15:0] m_rf [8] = '{default: 16'h0};
    logic [15:0] m_wd = '0;
    logic [2:0]  m_ws = '0, m_rs1 = '0, m_rs2 = '0;
    bit          m_z = 1'b0, m_n = 1'b0;

    always @(negedge clk) begin
        bit exp_ready;
        if (cyc == m_we_at) begin
            m_z = (m_wd == 16'h0);
            m_n = m_wd[15];
        end
        exp_ready = reset_n && (cyc >= m_idle_from);
        if (chk_en) begin
            chk("i_ready", 32'(i_ready), 32'(exp_ready));
            chk("o_we", 32'(o_we), 32'(cyc == m_we_at));
            chk("o_illegal", 32'(o_illegal), 32'(cyc == m_ill_at));
            chk("o_z", 32'(o_z), 32'(m_z));
            chk("o_n", 32'(o_n), 32'(m_n));
            chk("o_rs1", 32'(o_rs1), 32'(m_rs1));
            chk("o_rs2", 32'(o_rs2), 32'(m_rs2));
            if (cyc == m_we_at) begin
                chk("o_ws", 32'(o_ws), 32'(m_ws));
                chk("o_wd", 32'(o_wd), 32'(m_wd));
            end
        end
        if (o_we === 1'b1) we_count++;
        if (o_illegal === 1'b1) ill_count++;
        if (cyc == m_we_at) m_rf[m_ws] = m_wd;
        if (!reset_n) begin
            m_idle_from = cyc + 1;
            m_we_at = -1;
            m_ill_at = -1;
            m_z = 1'b0;
            m_n = 1'b0;
            m_rs1 = '0;
            m_rs2 = '0;
        end else if (exp_ready && i_valid) begin
            m_rs1 = i_rs1;
            m_rs2 = i_rs2;
            if (i_op == 3'd7 && !MUL_EN) begin
                m_ill_at = cyc + 2;
                m_idle_from = cyc + 2;
            end else begin
                m_ws = i_ws;
                m_wd = ref_op(int'(i_op), 32'(m_rf[i_rs1]), 32'(i_use_imm ? i_imm : m_rf[i_rs2]));
                m_we_at = cyc + ((i_op == 3'd7) ? 18 : 2);
                m_idle_from = m_we_at + 1;
            end
        end
    end

    // All stimulus tasks start and end at posedge+1
    task automatic issue(input int op, input int rs1, input int rs2, input int ws,
                         input logic [15:0] imm, input bit use_imm, output int acc);
        i_op = 3'(op);
        i_rs1 = 3'(rs1);
        i_rs2 = 3'(rs2);
        i_ws = 3'(ws);
        i_imm = imm;
        i_use_imm = use_imm;
        i_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 60 && acc < 0; n++) begin
            @(negedge clk);
            if (i_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cyc;
            end
        end
        if (acc < 0) begin
            chk("issue_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_we(input int limit, output int we_cyc, output logic [15:0] wd,
                           output logic [2:0] ws, output logic z, output logic n, output int rdy_cnt);
        we_cyc = -1;
        rdy_cnt = 0;
        wd = '0; ws = '0; z = 1'b0; n = 1'b0;
        for (int k = 0; k < limit && we_cyc < 0; k++) begin
            @(negedge clk);
            if (i_ready === 1'b1) rdy_cnt++;
            if (o_we === 1'b1) begin
                we_cyc = cyc;
                wd = o_wd; ws = o_ws; z = o_z; n = o_n;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int r, input logic [15:0] v);
        int acc;
        issue(0, 0, 0, r, v, 1'b1, acc);
        i_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a1, a2, a3, wc, rdy, wc0, ic0;
        logic [15:0] wd;
        logic [2:0] ws;
        logic z, n;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(i_ready), 32'd0);
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_wd", 32'(o_wd), 32'd0);
        chk("rst_ws", 32'(o_ws), 32'd0);
        chk("rst_rs", 32'({o_rs1, o_rs2}), 32'd0);
        chk("rst_flags", 32'({o_z, o_n, o_illegal}), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(i_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int r = 0; r < 8; r++) set_reg(r, 16'($urandom));

        set_reg(1, 16'hFFFF);
        set_reg(2, 16'h0002);
        issue(1, 1, 2, 5, 16'h0, 1'b0, a1);
        i_valid = 1'b0;
        wait_we(10, wc, wd, ws, z, n, rdy);
        chk("add_latency", 32'(wc + 1 - a1), 32'd2);
        chk("add_wd", 32'(wd), 32'h0001);
        chk("add_ws", 32'(ws), 32'd5);
        chk("add_zn", 32'({z, n}), 32'd0);

        set_reg(3, 16'h0003);
        issue(2, 3, 0, 6, 16'h0003, 1'b1, a1);
        i_valid = 1'b0;
        wait_we(10, wc, wd, ws, z, n, rdy);
        chk("subi_wd", 32'(wd), 32'h0000);
        chk("subi_z", 32'(z), 32'd1);

        set_reg(4, 16'h8001);
        set_reg(7, 16'h0011);
        issue(6, 4, 7, 0, 16'h0, 1'b0, a1);
        i_valid = 1'b0;
        wait_we(10, wc, wd, ws, z, n, rdy);
        chk("shl_wd", 32'(wd), 32'h0002);
        chk("shl_n", 32'(n), 32'd0);

        set_reg(1, 16'h0123);
        set_reg(2, 16'h0010);
        ic0 = ill_count;
        issue(7, 1, 2, 3, 16'h0, 1'b0, a1);
        i_valid = 1'b0;
        wait_we(25, wc, wd, ws, z, n, rdy);
`ifdef EXEC_MUL_EN
        chk("mul_latency", 32'(wc + 1 - a1), 32'd18);
        chk("mul_wd", 32'(wd), 32'h1230);
        chk("mul_ready_low", 32'(rdy), 32'd0);
`else
        chk("nomul_no_we", 32'(wc), 32'hFFFF_FFFF);
        chk("nomul_illegal", 32'(ill_count - ic0), 32'd1);
`endif

        set_reg(3, 16'h0100);
        set_reg(4, 16'h0023);
        idle(3);
        wc0 = we_count;
        issue(1, 3, 4, 1, 16'h0, 1'b0, a1);
        issue(1, 1, 1, 2, 16'h0, 1'b0, a2);
        issue(5, 2, 0, 5, 16'h00FF, 1'b1, a3);
        i_valid = 1'b0;
        idle(6);
        chk("b2b_gap1", 32'(a2 - a1), 32'd3);
        chk("b2b_gap2", 32'(a3 - a2), 32'd3);
        chk("b2b_writes", 32'(we_count - wc0), 32'd3);
        chk("dep_r2", 32'(tb_rf[2]), 32'h0246);
        chk("dep_r5", 32'(tb_rf[5]), 32'h02B9);

        set_reg(1, 16'h0123);
        set_reg(2, 16'h0010);
        idle(3);
        wc0 = we_count;
        issue(7, 1, 2, 4, 16'h0, 1'b0, a1);
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(25);
        chk("rst_mul_no_we", 32'(we_count - wc0), 32'd0);
        issue(1, 1, 2, 6, 16'h0, 1'b0, a1);
        i_valid = 1'b0;
        wait_we(10, wc, wd, ws, z, n, rdy);
        chk("post_rst_latency", 32'(wc + 1 - a1), 32'd2);
        chk("post_rst_wd", 32'(wd), 32'h0133);

        for (int i = 0; i < 80; i++) begin
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)), a1);
            if ($urandom_range(0, 3) != 0) i_valid = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 19)) @(posedge clk);
                #1;
                reset_n = 1'b0;
                idle(int'($urandom_range(1, 2)));
                reset_n = 1'b1;
            end else if ($urandom_range(0, 4) == 0) begin
                idle(int'($urandom_range(1, 6)));
            end
        end
        i_valid = 1'b0;
        idle(25);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
